icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache between the pipeline's fetch stage and the off-chip memory port. Serves 32-bit instruction words to fetch on hit; on miss, refills a whole line over the off-chip line interface (line-wide data, level read strobe, ready pulse) and replays the lookup. Supports full invalidation for `fence.i`, and exposes wrapping hit/miss counters for simulation statistics.

## Interface
- LINE_BYTES, 16: bytes per line; equals `CACHE_LINE_SIZE`; power of two, ≥4.
- NUM_LINES, 16: number of lines; power of two, ≥2.
- ADDR_W, 32: byte-address width; equals `MAX_BIT_POS`+1.
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch wants a word at fetch_addr.
- fetch_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- fetch_ready  out  1  request accepted this cycle when fetch_req && fetch_ready.
- fetch_valid  out  1  fetch_instr valid this cycle.
- fetch_instr  out  32  instruction word.
- flush  in  1  invalidate all lines.
- offchip_mem_read_en  out  1  line read strobe, level.
- offchip_mem_addr  out  ADDR_W  line-aligned byte address.
- offchip_mem_data  in  LINE_BYTES*8  refill line; byte i at [i*8 +: 8].
- offchip_mem_ready  in  1  refill data valid; may stay high several cycles.
- perf_hits  out  32  lookups that hit; wraps.
- perf_misses  out  32  lookups that missed; wraps.

## Operation
- Address split: offset = low log2(LINE_BYTES) bits, word = offset[..:2], index = next log2(NUM_LINES) bits, tag = remaining upper bits. Word w of a line = line[w*32 +: 32] (little-endian).
- Storage: per line a valid bit, tag, LINE_BYTES*8 data register.
- States: IDLE, LOOKUP, REFILL, DRAIN.
- IDLE: fetch_ready=1. Accept → latch address, go LOOKUP.
- LOOKUP: hit = valid[index] && tag match on the latched address. Hit: fetch_valid=1, fetch_instr=selected word, perf_hits+1; fetch_ready=1, and a new accepted request re-enters LOOKUP (back-to-back), otherwise IDLE. Miss: fetch_ready=0, perf_misses+1; go REFILL if offchip_mem_ready=0, else DRAIN (stale ready must clear first).
- REFILL: offchip_mem_read_en=1, offchip_mem_addr = latched address with offset bits zeroed, both held stable. On a cycle sampling offchip_mem_ready=1: write data, tag, set valid; go DRAIN.
- DRAIN: read_en=0; wait for offchip_mem_ready=0, then go LOOKUP (replay; hit is not counted twice — replay hit increments perf_hits only, not perf_misses).
- flush in IDLE/LOOKUP: all valid bits cleared next edge; a LOOKUP in the same cycle uses pre-flush valid bits. flush in REFILL/DRAIN: latched as pending, applied on DRAIN exit (refilled line included); replay then misses and refills again.
- Outputs other than fetch_ready/fetch_valid/fetch_instr are registered.

## Timing
- Reset: state IDLE, all valid=0, pending flush=0, offchip_mem_read_en=0, offchip_mem_addr=0, perf counters=0, fetch_valid=0, fetch_instr=0, fetch_ready=1 after the reset edge.
- Hit latency: accept at cycle N → fetch_valid at N+1; sustained 1 word/cycle on consecutive hits.
- Miss: accept N, miss in LOOKUP N+1, read_en rises N+2. If ready first sampled high at cycle R, read_en low at R+1; ready low sampled at D → LOOKUP at D+1 with fetch_valid=1.
- read_en never reasserts while offchip_mem_ready is high; every refill produces exactly one read_en rising edge.
- Reset mid-REFILL/DRAIN: read_en low next cycle, no line written, outstanding ready ignored; next miss waits in DRAIN until ready low.
- Counters wrap 0xFFFFFFFF→0.

## Test plan
- Cold miss: fetch 0x00000000, memory returns line 0x…33221100 words, ready held 2 cycles → one read_en pulse, addr 0x00, fetch_instr=word0, perf_misses=1, perf_hits=1.
- Back-to-back hits: after the above, fetch 0x4,0x8,0xC consecutively → fetch_valid on 3 consecutive cycles, words 1-3, no read_en.
- Conflict eviction: fetch 0x000, then 0x100 (same index, NUM_LINES=16), then 0x000 → three refills, addrs 0x000,0x100,0x000.
- Flush: warm line 0x000, pulse flush in IDLE, fetch 0x000 → miss and refill; flush during REFILL → replay misses, second refill issued.
- Stale ready: assert rst during REFILL while memory raises ready 1 cycle later; next fetch miss → read_en stays low until ready falls, then exactly one rising edge.
- Counter wrap: preload perf_hits=0xFFFFFFFF via force, one hit → 0.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: fetch port on the hit path, line refill from off-chip on miss.
// Latency: hit returns one cycle after accept; a miss costs refill plus ready-drain plus one replay cycle.
// Backpressure: fetch_ready drops from the missing lookup until the replay; off-chip ready must fall before read_en can reassert.
module icache #(
    parameter int LINE_BYTES = 16,
    parameter int NUM_LINES  = 16,
    parameter int ADDR_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_req,
    input  logic [ADDR_W-1:0]       fetch_addr,
    output logic                    fetch_ready,
    output logic                    fetch_valid,
    output logic [31:0]             fetch_instr,
    input  logic                    flush,
    output logic                    offchip_mem_read_en,
    output logic [ADDR_W-1:0]       offchip_mem_addr,
    input  logic [LINE_BYTES*8-1:0] offchip_mem_data,
    input  logic                    offchip_mem_ready,
    output logic [31:0]             perf_hits,
    output logic [31:0]             perf_misses
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int LINE_W = LINE_BYTES * 8;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q;
    logic [NUM_LINES-1:0]   valid_q;
    logic [TAG_W-1:0]       tag_q  [NUM_LINES];
    logic [LINE_W-1:0]      data_q [NUM_LINES];
    logic                   flush_pend_q;
    logic                   replay_q;

    logic [IDX_W-1:0]       idx;
    logic [TAG_W-1:0]       tag;
    logic [OFF_W-1:0]       byte_off;
    logic                   hit;
    logic                   accept, count_hit, count_miss, start_refill, fill, drain_done;
    logic                   flush_now;

    assign idx      = addr_q[OFF_W +: IDX_W];
    assign tag      = addr_q[ADDR_W-1 -: TAG_W];
    assign byte_off = addr_q[OFF_W-1:0] & ~OFF_W'(3);
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        state_d      = state_q;
        fetch_ready  = 1'b0;
        fetch_valid  = 1'b0;
        fetch_instr  = '0;
        accept       = 1'b0;
        count_hit    = 1'b0;
        count_miss   = 1'b0;
        start_refill = 1'b0;
        fill         = 1'b0;
        drain_done   = 1'b0;
        case (state_q)
            IDLE: begin
                fetch_ready = 1'b1;
                if (fetch_req) begin
                    accept  = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    fetch_valid = 1'b1;
                    fetch_instr = data_q[idx][{byte_off, 3'b000} +: 32];
                    count_hit   = 1'b1;
                    fetch_ready = 1'b1;
                    accept      = fetch_req;
                    state_d     = fetch_req ? LOOKUP : IDLE;
                end else begin
                    // a replayed lookup was already counted as a miss when first seen
                    count_miss = !replay_q;
                    if (offchip_mem_ready) begin
                        state_d = DRAIN;
                    end else begin
                        start_refill = 1'b1;
                        state_d      = REFILL;
                    end
                end
            end
            REFILL: begin
                if (offchip_mem_ready) begin
                    fill    = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!offchip_mem_ready) begin
                    drain_done = 1'b1;
                    state_d    = LOOKUP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // flush during refill/drain is deferred so the in-flight line is discarded too
    assign flush_now = (flush && (state_q == IDLE || state_q == LOOKUP)) ||
                       (drain_done && (flush_pend_q || flush));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= IDLE;
            addr_q              <= '0;
            valid_q             <= '0;
            flush_pend_q        <= 1'b0;
            replay_q            <= 1'b0;
            offchip_mem_read_en <= 1'b0;
            offchip_mem_addr    <= '0;
            perf_hits           <= '0;
            perf_misses         <= '0;
        end else begin
            state_q  <= state_d;
            replay_q <= drain_done;
            if (accept) addr_q <= fetch_addr;
            if (start_refill) begin
                offchip_mem_read_en <= 1'b1;
                offchip_mem_addr    <= {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end
            if (fill) offchip_mem_read_en <= 1'b0;
            if (count_hit)  perf_hits   <= perf_hits + 32'd1;
            if (count_miss) perf_misses <= perf_misses + 32'd1;
            if (fill) valid_q[idx] <= 1'b1;
            if (flush_now) valid_q <= '0;
            if (flush && (state_q == REFILL || state_q == DRAIN)) flush_pend_q <= 1'b1;
            if (drain_done) flush_pend_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (fill && !rst) begin
            data_q[idx] <= offchip_mem_data;
            tag_q[idx]  <= tag;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: scoreboard of expected fetch words and refill addresses, checked by monitors.
module tb_icache;
    localparam int LB = 16;

    typedef struct {
        logic [31:0] word;
        int          acc;
        bit          exact;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            fetch_req;
    logic [31:0]     fetch_addr;
    logic            fetch_ready, fetch_valid;
    logic [31:0]     fetch_instr;
    logic            flush;
    logic            offchip_mem_read_en;
    logic [31:0]     offchip_mem_addr;
    logic [LB*8-1:0] mem_data;
    logic            auto_rdy, man_rdy, mem_ready;
    logic [31:0]     perf_hits, perf_misses;

    bit              mem_auto;
    int              mem_lat;
    int              cyc = 0;
    int              rises = 0;
    int              ntests = 0;
    int              nfail = 0;
    exp_t            exp_q[$];
    logic [31:0]     exp_addr[$];

    assign mem_ready = auto_rdy | man_rdy;

    icache dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
        .flush(flush),
        .offchip_mem_read_en(offchip_mem_read_en), .offchip_mem_addr(offchip_mem_addr),
        .offchip_mem_data(mem_data), .offchip_mem_ready(mem_ready),
        .perf_hits(perf_hits), .perf_misses(perf_misses)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory content: byte i of line 0 is 0x11*i; other lines XOR in their line address.
    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [31:0] w;
        w = 32'(a[3:2]);
        return (32'h33221100 + 32'h44444444 * w) ^ {a[31:4], 4'h0};
    endfunction

    function automatic logic [LB*8-1:0] make_line(input logic [31:0] la);
        logic [LB*8-1:0] l;
        for (int w = 0; w < LB / 4; w++) l[w*32 +: 32] = exp_word(la + 32'(4 * w));
        return l;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        ntests++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Off-chip memory: answers a read strobe after mem_lat cycles, ready held two cycles.
    initial begin
        auto_rdy = 1'b0;
        mem_data = '0;
        forever begin
            @(negedge clk);
            if (mem_auto && offchip_mem_read_en && !auto_rdy) begin
                repeat (mem_lat) @(negedge clk);
                mem_data = make_line(offchip_mem_addr);
                auto_rdy = 1'b1;
                repeat (2) @(negedge clk);
                auto_rdy = 1'b0;
            end
        end
    end

    // Fetch-response monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (fetch_valid) begin
                ntests++;
                if (exp_q.size() == 0) begin
                    nfail++;
                    $display("FAIL fetch_unexpected: got %h expected no response", fetch_instr);
                end else begin
                    e = exp_q.pop_front();
                    if (fetch_instr !== e.word) begin
                        nfail++;
                        $display("FAIL fetch_word: got %h expected %h", fetch_instr, e.word);
                    end else if (e.exact && (cyc - e.acc != 1)) begin
                        nfail++;
                        $display("FAIL hit_latency: got %0d expected 1", cyc - e.acc);
                    end
                end
            end
        end
    end

    // Refill-strobe monitor: every rising edge must match the next expected line address with ready low.
    initial begin
        logic        prev;
        logic [31:0] a;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (offchip_mem_read_en && !prev) begin
                rises++;
                ntests++;
                if (exp_addr.size() == 0) begin
                    nfail++;
                    $display("FAIL refill_unexpected: got addr %h expected no refill", offchip_mem_addr);
                end else begin
                    a = exp_addr.pop_front();
                    if (offchip_mem_addr !== a || mem_ready) begin
                        nfail++;
                        $display("FAIL refill_addr: got %h ready=%0b expected %h ready=0",
                                 offchip_mem_addr, mem_ready, a);
                    end
                end
            end
            prev = offchip_mem_read_en;
        end
    end

    task automatic issue(input logic [31:0] a, input bit push, input bit exact);
        int n;
        @(negedge clk);
        fetch_req  = 1'b1;
        fetch_addr = a;
        #1;
        n = 0;
        while (!fetch_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!fetch_ready) begin
            ntests++;
            nfail++;
            $display("FAIL accept_timeout: got fetch_ready=0 expected 1 for %h", a);
            fetch_req = 1'b0;
            return;
        end
        if (push) exp_q.push_back('{exp_word(a), cyc, exact});
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        fetch_req = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("responses_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_ren();
        int n;
        n = 0;
        while (!offchip_mem_read_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!offchip_mem_read_en) begin
            ntests++;
            nfail++;
            $display("FAIL read_en_timeout: got 0 expected 1");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", ntests, nfail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, h0;
        rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; flush = 1'b0;
        man_rdy = 1'b0; mem_auto = 1'b1; mem_lat = 1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_fetch_instr", fetch_instr, 32'd0);
        chk("rst_read_en", 32'(offchip_mem_read_en), 32'd0);
        chk("rst_mem_addr", offchip_mem_addr, 32'd0);
        chk("rst_hits", perf_hits, 32'd0);
        chk("rst_misses", perf_misses, 32'd0);

        // cold miss
        exp_addr.push_back(32'h000);
        issue(32'h000, 1, 0);
        idle();
        wait_done();
        chk("cold_misses", perf_misses, 32'd1);
        chk("cold_hits", perf_hits, 32'd1);
        chk("cold_rises", 32'(rises), 32'd1);

        // back-to-back hits within the line
        issue(32'h004, 1, 1);
        issue(32'h008, 1, 1);
        issue(32'h00C, 1, 1);
        idle();
        wait_done();
        chk("b2b_rises", 32'(rises), 32'd1);
        chk("b2b_hits", perf_hits, 32'd4);

        // conflict eviction on index 0
        exp_addr.push_back(32'h100);
        exp_addr.push_back(32'h000);
        issue(32'h100, 1, 0);
        idle();
        wait_done();
        issue(32'h000, 1, 0);
        idle();
        wait_done();
        issue(32'h008, 1, 1);
        idle();
        wait_done();
        chk("conflict_rises", 32'(rises), 32'd3);
        chk("conflict_misses", perf_misses, 32'd3);

        // flush while idle
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        exp_addr.push_back(32'h000);
        issue(32'h004, 1, 0);
        idle();
        wait_done();
        chk("flush_idle_rises", 32'(rises), 32'd4);

        // flush during refill: replay misses and refetches the same line
        h0 = int'(perf_hits);
        mem_lat = 4;
        exp_addr.push_back(32'h020);
        exp_addr.push_back(32'h020);
        issue(32'h024, 1, 0);
        idle();
        wait_ren();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_done();
        mem_lat = 1;
        chk("flush_refill_rises", 32'(rises), 32'd6);
        chk("flush_refill_hits", perf_hits, 32'(h0 + 1));

        // reset mid-refill with a stale ready arriving afterwards
        mem_auto = 1'b0;
        exp_addr.push_back(32'h040);
        issue(32'h040, 0, 0);
        idle();
        wait_ren();
        r0 = rises;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        man_rdy = 1'b1;
        #1;
        chk("stale_rst_read_en", 32'(offchip_mem_read_en), 32'd0);
        chk("stale_rst_misses", perf_misses, 32'd0);
        issue(32'h048, 1, 0);
        idle();
        repeat (4) @(negedge clk);
        chk("stale_hold_read_en", 32'(offchip_mem_read_en), 32'd0);
        exp_addr.push_back(32'h040);
        man_rdy = 1'b0;
        mem_auto = 1'b1;
        wait_done();
        chk("stale_rises", 32'(rises), 32'(r0 + 1));
        chk("stale_misses", perf_misses, 32'd1);
        chk("stale_hits", perf_hits, 32'd1);

        // hit counter wrap
        @(negedge clk);
        force dut.perf_hits = 32'hFFFFFFFF;
        @(negedge clk);
        release dut.perf_hits;
        issue(32'h04C, 1, 1);
        idle();
        wait_done();
        chk("wrap_hits", perf_hits, 32'd0);

        chk("refills_outstanding", 32'(exp_addr.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
